// File: rtl/apb_rr_master.sv
// apb_rr_master
// APB master shared by two requesters through a round-robin arbiter. Only
// one APB transfer is in flight at a time. A transfer that sees no pready
// for TIMEOUT ACCESS cycles is aborted and reported as an error.
//
// Ports
//   pclk, presetn            clock, synchronous active-low reset
//   req0/1, we0/1            requester level request and direction (1 = write)
//   addr0/1, wdata0/1        requester address and write data
//   done0/1                  one-cycle completion pulse per requester
//   rdata                    data of the last successful read
//   err                      status of the completing transfer (valid with done)
//   psel, penable, pwrite    APB control
//   paddr, pwdata            APB address / write data
//   prdata, pready, pslverr  APB slave response
//
// state  | meaning
// IDLE   | no transfer; arbitrate among unmasked requests
// SETUP  | APB setup phase (psel=1, penable=0)
// ACCESS | APB access phase, waiting for pready or timeout
module apb_rr_master #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        req0,
  input  logic        req1,
  input  logic        we0,
  input  logic        we1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        done0,
  output logic        done1,
  output logic [31:0] rdata,
  output logic        err,
  output logic        psel,
  output logic        penable,
  output logic        pwrite,
  output logic [31:0] paddr,
  output logic [31:0] pwdata,
  input  logic [31:0] prdata,
  input  logic        pready,
  input  logic        pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t      state, state_n;
  logic        psel_n, penable_n, pwrite_n;
  logic [31:0] paddr_n, pwdata_n, rdata_n;
  logic        done0_n, done1_n, err_n;
  logic [7:0]  wait_cnt, wait_cnt_n, wait_inc;
  // owner: requester of the current/most recent grant; also the
  // round-robin pointer (a tie goes to the other requester).
  logic        owner, owner_n;
  logic        req_m0, req_m1, win;

  // A requester is masked in the cycle its done pulse is high, since it is
  // still holding req for the transfer that just finished.
  assign req_m0   = req0 & ~done0;
  assign req_m1   = req1 & ~done1;
  assign wait_inc = wait_cnt + 8'd1;

  always_ff @(posedge pclk) begin
    if (!presetn) begin
      state    <= IDLE;
      psel     <= 1'b0;
      penable  <= 1'b0;
      pwrite   <= 1'b0;
      paddr    <= '0;
      pwdata   <= '0;
      rdata    <= '0;
      err      <= 1'b0;
      done0    <= 1'b0;
      done1    <= 1'b0;
      wait_cnt <= '0;
      owner    <= 1'b1;
    end else begin
      state    <= state_n;
      psel     <= psel_n;
      penable  <= penable_n;
      pwrite   <= pwrite_n;
      paddr    <= paddr_n;
      pwdata   <= pwdata_n;
      rdata    <= rdata_n;
      err      <= err_n;
      done0    <= done0_n;
      done1    <= done1_n;
      wait_cnt <= wait_cnt_n;
      owner    <= owner_n;
    end
  end

  always_comb begin
    state_n    = state;
    psel_n     = psel;
    penable_n  = penable;
    pwrite_n   = pwrite;
    paddr_n    = paddr;
    pwdata_n   = pwdata;
    rdata_n    = rdata;
    err_n      = 1'b0;
    done0_n    = 1'b0;
    done1_n    = 1'b0;
    wait_cnt_n = wait_cnt;
    owner_n    = owner;
    win        = (req_m0 && req_m1) ? ~owner : req_m1;

    case (state)
      IDLE: begin
        psel_n    = 1'b0;
        penable_n = 1'b0;
        if (req_m0 || req_m1) begin
          owner_n  = win;
          pwrite_n = win ? we1    : we0;
          paddr_n  = win ? addr1  : addr0;
          pwdata_n = win ? wdata1 : wdata0;
          psel_n   = 1'b1;
          state_n  = SETUP;
        end
      end

      SETUP: begin
        penable_n  = 1'b1;
        wait_cnt_n = '0;
        state_n    = ACCESS;
      end

      ACCESS: begin
        if (pready) begin
          psel_n    = 1'b0;
          penable_n = 1'b0;
          err_n     = pslverr;
          if (owner) done1_n = 1'b1;
          else       done0_n = 1'b1;
          // An errored read leaves rdata untouched.
          if (!pwrite && !pslverr) rdata_n = prdata;
          state_n = IDLE;
        end else begin
          wait_cnt_n = wait_inc;
          if (wait_inc == TIMEOUT_CNT) begin
            psel_n    = 1'b0;
            penable_n = 1'b0;
            err_n     = 1'b1;
            if (owner) done1_n = 1'b1;
            else       done0_n = 1'b1;
            state_n = IDLE;
          end
        end
      end

      default: begin
        psel_n    = 1'b0;
        penable_n = 1'b0;
        state_n   = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_apb_rr_master.sv
// tb_apb_rr_master
// Directed scenarios followed by randomized traffic. Expected behaviour comes
// from a transaction-level model: pending requests per requester, the last
// grant, and the last successful read value.
module tb_apb_rr_master;
  localparam int TO = 4;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        done0, done1, err, psel, penable, pwrite;
  logic [31:0] rdata, paddr, pwdata;
  logic [31:0] prdata = '0;
  logic        pready = 1'b0, pslverr = 1'b0;

  int tests = 0;
  int fails = 0;

  // model state
  bit          pend [2];
  bit          mwe  [2];
  logic [31:0] maddr [2];
  logic [31:0] mwdata [2];
  int          last = 1;
  int          just_done = -1;
  logic [31:0] m_rdata = '0;

  apb_rr_master #(.TIMEOUT(TO)) dut (
    .pclk(pclk), .presetn(presetn),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .done0(done0), .done1(done1), .rdata(rdata), .err(err),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic apply_reqs();
    req0 = pend[0]; we0 = mwe[0]; addr0 = maddr[0]; wdata0 = mwdata[0];
    req1 = pend[1]; we1 = mwe[1]; addr1 = maddr[1]; wdata1 = mwdata[1];
  endtask

  task automatic new_req(input int n);
    pend[n]   = 1'b1;
    mwe[n]    = 1'($urandom);
    maddr[n]  = $urandom;
    mwdata[n] = $urandom;
  endtask

  task automatic set_req(input int n, input bit we, input logic [31:0] a, input logic [31:0] d);
    pend[n] = 1'b1; mwe[n] = we; maddr[n] = a; mwdata[n] = d;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_psel"},    psel,    0);
    chk({tag, "_penable"}, penable, 0);
    chk({tag, "_pwrite"},  pwrite,  0);
    chk({tag, "_paddr"},   paddr,   0);
    chk({tag, "_pwdata"},  pwdata,  0);
    chk({tag, "_rdata"},   rdata,   0);
    chk({tag, "_err"},     err,     0);
    chk({tag, "_done0"},   done0,   0);
    chk({tag, "_done1"},   done1,   0);
  endtask

  task automatic model_reset();
    last = 1; just_done = -1; m_rdata = '0;
  endtask

  // One complete transfer. The slave withholds pready for `waits` ACCESS
  // cycles, then answers with rd/slv. The master gives up after TO
  // ACCESS cycles without pready.
  task automatic do_xfer(input int waits, input bit slv, input logic [31:0] rd);
    bit r0, r1, e_err, fin;
    int w;
    r0 = pend[0] && just_done != 0;
    r1 = pend[1] && just_done != 1;
    if (!r0 && !r1) begin
      // only the requester that just finished is asking: it is masked for a cycle
      step();
      chk("mask_idle_psel", psel, 0);
      chk("mask_idle_done0", done0, 0);
      chk("mask_idle_done1", done1, 0);
      r0 = pend[0]; r1 = pend[1];
    end
    just_done = -1;
    if (r0 && r1) w = (last == 0) ? 1 : 0;
    else          w = r1 ? 1 : 0;
    last = w;

    step();
    chk("setup_psel", psel, 1);
    chk("setup_penable", penable, 0);
    chk("setup_pwrite", pwrite, mwe[w]);
    chk("setup_paddr", paddr, maddr[w]);
    chk("setup_pwdata", pwdata, mwdata[w]);
    chk("setup_done0", done0, 0);
    chk("setup_done1", done1, 0);
    chk("setup_err", err, 0);
    chk("setup_rdata", rdata, m_rdata);
    step();

    fin = 1'b0;
    for (int c = 1; c <= TO && !fin; c++) begin
      chk("access_psel", psel, 1);
      chk("access_penable", penable, 1);
      chk("access_paddr", paddr, maddr[w]);
      chk("access_done", {done0, done1}, 0);
      chk("access_err", err, 0);
      if (c - 1 == waits) begin
        pready = 1'b1; prdata = rd; pslverr = slv;
      end else begin
        pready = 1'b0; prdata = $urandom; pslverr = 1'($urandom);
      end
      step();
      pready = 1'b0; pslverr = 1'b0;
      if (c - 1 == waits) begin
        fin = 1'b1; e_err = slv;
        if (!mwe[w] && !slv) m_rdata = rd;
      end else if (c == TO) begin
        fin = 1'b1; e_err = 1'b1;
      end
      if (fin) begin
        chk("done_psel", psel, 0);
        chk("done_penable", penable, 0);
        chk("done_done0", done0, (w == 0));
        chk("done_done1", done1, (w == 1));
        chk("done_err", err, e_err);
        chk("done_rdata", rdata, m_rdata);
        chk("done_paddr_hold", paddr, maddr[w]);
        pend[w] = 1'b0;
        just_done = w;
      end
    end
  endtask

  initial begin
    pend[0] = 0; pend[1] = 0; mwe[0] = 0; mwe[1] = 0;
    maddr[0] = '0; maddr[1] = '0; mwdata[0] = '0; mwdata[1] = '0;

    presetn = 1'b0;
    step(); step();
    check_reset("reset");
    presetn = 1'b1;

    // single write from requester 0
    set_req(0, 1'b1, 32'd5, 32'hDEADBEEF); apply_reqs();
    do_xfer(0, 1'b0, 32'h0);
    apply_reqs();
    step();
    chk("single_wr_done0_once", done0, 0);

    // write then read from requester 1
    set_req(1, 1'b1, 32'd3, 32'h12345678); apply_reqs();
    do_xfer(1, 1'b0, 32'h0);
    set_req(1, 1'b0, 32'd3, 32'h0); apply_reqs();
    do_xfer(0, 1'b0, 32'h12345678);
    chk("wr_rd_rdata", rdata, 32'h12345678);
    apply_reqs();

    // slave error on a read leaves rdata alone
    set_req(0, 1'b0, 32'd40, 32'h0); apply_reqs();
    do_xfer(0, 1'b1, 32'hBAD0BAD0);
    chk("slverr_err", err, 1);
    chk("slverr_rdata_held", rdata, 32'h12345678);
    apply_reqs();

    // timeout abort, then a normal transfer
    set_req(1, 1'b1, 32'h100, 32'hCAFEF00D); apply_reqs();
    do_xfer(TO + 3, 1'b0, 32'h0);
    chk("timeout_err", err, 1);
    set_req(0, 1'b0, 32'h104, 32'h0); apply_reqs();
    do_xfer(2, 1'b0, 32'h0BADF00D);
    apply_reqs();

    // reset during ACCESS: no done, outputs back to reset values
    set_req(1, 1'b0, 32'd7, 32'h0); apply_reqs();
    step();
    for (int i = 0; i < 6 && !(psel && penable); i++) step();
    chk("rst_reached_access", penable, 1);
    new_req(0); apply_reqs();
    pready = 1'b0;
    presetn = 1'b0;
    step();
    presetn = 1'b1;
    check_reset("rst_mid");
    model_reset();

    // both held from reset: grants alternate starting with requester 0
    for (int i = 0; i < 4; i++) begin
      do_xfer($urandom_range(0, 2), 1'b0, $urandom);
      new_req(last); apply_reqs();
    end

    // randomized traffic
    for (int t = 0; t < 40; t++) begin
      for (int n = 0; n < 2; n++)
        if (!pend[n] && ($urandom_range(0, 1) == 1)) new_req(n);
      if (!pend[0] && !pend[1]) new_req($urandom_range(0, 1));
      apply_reqs();
      do_xfer($urandom_range(0, TO + 1), ($urandom_range(0, 3) == 0), $urandom);
      apply_reqs();
    end
    step();
    chk("final_done0", done0, 0);
    chk("final_done1", done1, 0);
    chk("final_err", err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
